// File: rtl/fp_exce_responder.sv
// Turns the FPU_8 exception verdict into the special minifloat result (s|eeee|mmm),
// with sticky exception flags and a saturating exceptional-request counter.
module fp_exce_responder #(
  parameter int         COUNT_W    = 8,
  parameter logic [7:0] QNAN_VALUE = 8'h7C
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [1:0]         FP_OPERATION,
  input  logic [7:0]         OP_A,
  input  logic [7:0]         OP_B,
  input  logic               OP_IS_EXCEPTION,
  input  logic [2:0]         FP_EXCE,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic               RES_SPECIAL,
  output logic [7:0]         RES_VALUE,
  output logic [2:0]         RES_EXCE,
  output logic [3:0]         FLAGS,
  input  logic               FLAGS_CLR,
  output logic [COUNT_W-1:0] EXCE_COUNT
);

  // Exception code encoding shared with the detector.
  localparam logic [2:0] NO_EXCE       = 3'd0;
  localparam logic [2:0] QNAN_EXCE     = 3'd1;
  localparam logic [2:0] SNAN_EXCE     = 3'd2;
  localparam logic [2:0] INF_EXCE      = 3'd3;
  localparam logic [2:0] ZERO_DIV_EXCE = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_QUIET, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         opa_q, opb_q;
  logic [7:0]         value_q;
  logic               special_q;
  logic [2:0]         exce_q;
  logic [3:0]         flags_q, flags_d;
  logic [COUNT_W-1:0] count_q, count_d, cnt_base;

  logic       accept;
  logic [2:0] eff_code;
  logic [7:0] acc_value;
  logic       acc_special;
  logic [2:0] acc_set;  // {NP, DZ, NV}

  // The operation code does not influence the special result.
  logic unused_op;
  assign unused_op = ^FP_OPERATION;

  function automatic logic [7:0] quiet_nan(input logic [7:0] a, input logic [7:0] b);
    return (a[6:3] == 4'hF && a[2:0] != 3'b000) ? (a | 8'h04) : (b | 8'h04);
  endfunction

  assign accept   = IN_READY && IN_VALID;
  assign eff_code = OP_IS_EXCEPTION ? FP_EXCE : NO_EXCE;

  always_comb begin
    acc_value   = 8'h00;
    acc_special = 1'b0;
    acc_set     = 3'b000;
    if (OP_IS_EXCEPTION) begin
      acc_special = 1'b1;
      case (FP_EXCE)
        QNAN_EXCE: begin
          acc_value = quiet_nan(OP_A, OP_B);
          acc_set   = 3'b100;
        end
        // Value is formed in QUIET from the latched operands.
        SNAN_EXCE: acc_set = 3'b101;
        INF_EXCE: begin
          acc_value = QNAN_VALUE;
          acc_set   = 3'b001;
        end
        ZERO_DIV_EXCE: begin
          if (OP_A[6:0] == 7'h00) begin
            acc_value = QNAN_VALUE;
            acc_set   = 3'b001;
          end else begin
            acc_value = {OP_A[7] ^ OP_B[7], 7'h78};
            acc_set   = 3'b010;
          end
        end
        default: begin
          acc_value = QNAN_VALUE;
          acc_set   = 3'b001;
        end
      endcase
    end
  end

  // Clear first, then apply this cycle's sets so a coincident set survives.
  always_comb begin
    cnt_base = FLAGS_CLR ? '0 : count_q;
    flags_d  = FLAGS_CLR ? 4'b0000 : flags_q;
    count_d  = cnt_base;
    if (accept) begin
      flags_d[2:0] = flags_d[2:0] | acc_set;
      if (OP_IS_EXCEPTION) begin
        if (cnt_base != '1) count_d = cnt_base + COUNT_W'(1);
        if (count_d == '1) flags_d[3] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      opa_q     <= 8'h00;
      opb_q     <= 8'h00;
      value_q   <= 8'h00;
      special_q <= 1'b0;
      exce_q    <= NO_EXCE;
      flags_q   <= 4'b0000;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      count_q <= count_d;
      if (accept) begin
        opa_q     <= OP_A;
        opb_q     <= OP_B;
        value_q   <= acc_value;
        special_q <= acc_special;
        exce_q    <= eff_code;
      end else if (state_q == S_QUIET) begin
        value_q <= quiet_nan(opa_q, opb_q);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (IN_VALID) state_d = (eff_code == SNAN_EXCE) ? S_QUIET : S_OUT;
      S_QUIET: state_d = S_OUT;
      S_OUT:   if (RES_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == S_IDLE);
    RES_VALID = (state_q == S_OUT);
  end

  assign RES_SPECIAL = special_q;
  assign RES_VALUE   = value_q;
  assign RES_EXCE    = exce_q;
  assign FLAGS       = flags_q;
  assign EXCE_COUNT  = count_q;

endmodule

// File: tb/tb_fp_exce_responder.sv
// Directed plus randomized check of fp_exce_responder against a transaction-level model.
module tb_fp_exce_responder;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, op_is_exc, res_valid, res_ready, res_special, flags_clr;
  logic [1:0]    fp_op;
  logic [7:0]    op_a, op_b, res_value;
  logic [2:0]    fp_exce, res_exce;
  logic [3:0]    flags;
  logic [CW-1:0] exce_count;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  bit         m_busy, m_quiet, m_pres;
  logic [7:0] m_val;
  bit         m_sp;
  logic [2:0] m_exce;
  logic [3:0] m_flags;
  int         m_cnt;

  fp_exce_responder #(.COUNT_W(CW), .QNAN_VALUE(8'h7C)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .FP_OPERATION(fp_op), .OP_A(op_a), .OP_B(op_b),
    .OP_IS_EXCEPTION(op_is_exc), .FP_EXCE(fp_exce),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_SPECIAL(res_special),
    .RES_VALUE(res_value), .RES_EXCE(res_exce), .FLAGS(flags),
    .FLAGS_CLR(flags_clr), .EXCE_COUNT(exce_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_nan(input logic [7:0] x);
    return (x[6:3] == 4'hF) && (x[2:0] != 3'b000);
  endfunction

  // Rules: value, special, flag bits {NP,DZ,NV} and effective code of a request.
  task automatic resolve(input logic [7:0] a, input logic [7:0] b, input logic exc,
                         input logic [2:0] code, output logic [7:0] val, output bit sp,
                         output logic [2:0] set, output logic [2:0] eff);
    val = 8'h00; sp = 0; set = 3'b000; eff = exc ? code : 3'd0;
    if (exc) begin
      sp = 1;
      if (code == 3'd1 || code == 3'd2) begin
        val = is_nan(a) ? (a | 8'h04) : (b | 8'h04);
        set = (code == 3'd2) ? 3'b101 : 3'b100;
      end else if (code == 3'd4 && a[6:0] != 7'h00) begin
        val = {a[7] ^ b[7], 7'h78};
        set = 3'b010;
      end else begin
        val = 8'h7C;
        set = 3'b001;
      end
    end
  endtask

  task automatic model_step();
    bit acc;
    logic [7:0] v; bit s; logic [2:0] st, e;
    if (rst) begin
      m_busy = 0; m_quiet = 0; m_pres = 0;
      m_val = 8'h00; m_sp = 0; m_exce = 3'd0; m_flags = 4'h0; m_cnt = 0;
      return;
    end
    acc = !m_busy && in_valid;
    if (m_quiet) begin
      m_quiet = 0; m_pres = 1;
    end else if (m_pres && res_ready) begin
      m_pres = 0; m_busy = 0;
    end
    if (flags_clr) begin
      m_flags = 4'h0; m_cnt = 0;
    end
    if (acc) begin
      resolve(op_a, op_b, op_is_exc, fp_exce, v, s, st, e);
      m_busy = 1; m_quiet = (e == 3'd2); m_pres = !m_quiet;
      m_val = v; m_sp = s; m_exce = e;
      m_flags[2:0] = m_flags[2:0] | st;
      if (op_is_exc) begin
        if (m_cnt < CMAX) m_cnt++;
        if (m_cnt == CMAX) m_flags[3] = 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", in_ready, !m_busy);
    chk("res_valid", res_valid, m_pres);
    chk("flags", flags, m_flags);
    chk("exce_count", exce_count, m_cnt);
    if (m_pres) begin
      chk("res_value", res_value, m_val);
      chk("res_special", res_special, m_sp);
      chk("res_exce", res_exce, m_exce);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic req(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                     input logic exc, input logic [2:0] code);
    in_valid = 1; op_a = a; op_b = b; fp_op = op; op_is_exc = exc; fp_exce = code;
  endtask

  function automatic logic [7:0] pick_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: return {s, 7'h00};
      1: return {s, 4'hF, 3'b000};
      2: return {s, 4'hF, 1'b1, 2'($urandom_range(0, 3))};
      3: return {s, 4'hF, 1'b0, 2'($urandom_range(1, 3))};
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; in_valid = 0; op_a = 0; op_b = 0; fp_op = 0; op_is_exc = 0; fp_exce = 0;
    res_ready = 0; flags_clr = 0;
    cycle(); cycle();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_value", res_value, 8'h00);
    chk("rst_special", res_special, 1'b0);
    chk("rst_exce", res_exce, 3'd0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_count", exce_count, 0);
    rst = 0;

    // Divide by zero, nonzero dividend, negative zero divisor
    req(8'h38, 8'h80, 2'd3, 1, 3'd4); cycle();
    chk("t1_valid", res_valid, 1'b1);
    chk("t1_value", res_value, 8'hF8);
    chk("t1_special", res_special, 1'b1);
    chk("t1_flags", flags, 4'b0010);
    chk("t1_count", exce_count, 1);
    in_valid = 0; res_ready = 1; cycle();
    chk("t1_release", in_ready, 1'b1);

    // sNaN with coincident clear: set wins
    res_ready = 0; flags_clr = 1; req(8'h79, 8'h00, 2'd0, 1, 3'd2); cycle();
    chk("t2_quiet_valid", res_valid, 1'b0);
    chk("t2_quiet_ready", in_ready, 1'b0);
    chk("t2_flags", flags, 4'b0101);
    flags_clr = 0; in_valid = 0; cycle();
    chk("t2_valid", res_valid, 1'b1);
    chk("t2_value", res_value, 8'h7D);
    res_ready = 1; cycle();

    // INF under backpressure
    res_ready = 0; req(8'h00, 8'h78, 2'd2, 1, 3'd3); cycle();
    in_valid = 1; op_is_exc = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_value_hold", res_value, 8'h7C);
      chk("t3_ready_low", in_ready, 1'b0);
      chk("t3_valid_hold", res_valid, 1'b1);
      cycle();
    end
    in_valid = 0; res_ready = 1; cycle();
    chk("t3_released", res_valid, 1'b0);

    // Non-exceptional request with a stale INF code
    req(8'h40, 8'h41, 2'd0, 0, 3'd3); cycle();
    chk("t5_special", res_special, 1'b0);
    chk("t5_value", res_value, 8'h00);
    chk("t5_exce", res_exce, 3'd0);
    chk("t5_flags", flags, 4'b0101);
    chk("t5_count", exce_count, 2);
    in_valid = 0; cycle();

    // Saturation
    flags_clr = 1; cycle(); flags_clr = 0;
    for (int i = 1; i <= 4; i++) begin
      req(8'h7A, 8'h00, 2'd0, 1, 3'd1); cycle();
      chk("t4_count", exce_count, (i > 3) ? 3 : i);
      chk("t4_value", res_value, 8'h7E);
      if (i >= 3) chk("t4_sat", flags[3], 1'b1);
      in_valid = 0; cycle();
    end
    flags_clr = 1; req(8'h7A, 8'h00, 2'd0, 1, 3'd1); cycle();
    chk("t4_clr_count", exce_count, 1);
    chk("t4_clr_flags", flags, 4'b0100);
    flags_clr = 0; in_valid = 0; cycle();

    // Reset while in QUIET
    req(8'h79, 8'h00, 2'd1, 1, 3'd2); cycle();
    chk("t6_in_quiet", res_valid, 1'b0);
    rst = 1; in_valid = 0; cycle(); rst = 0;
    chk("t6_valid", res_valid, 1'b0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_flags", flags, 4'h0);
    chk("t6_count", exce_count, 0);

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flags_clr = ($urandom_range(0, 9) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      req(pick_op(), pick_op(), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      in_valid  = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
